// File: rtl/feat_bank_arb.sv
// Per-bank round-robin arbiter over the interleaved FeatureBuffer banks with fixed-latency read return.
// Optional conflict statistics counter enabled by defining FEAT_ARB_STATS_EN.
module feat_bank_arb #(
    parameter int N_REQ   = 4,
    parameter int ADDR_W  = 12,
    parameter int BANK_W  = 3,
    parameter int DATA_W  = 16,
    parameter int RAM_LAT = 1
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic [N_REQ-1:0]                       req_valid,
    input  logic [N_REQ-1:0]                       req_we,
    input  logic [N_REQ*ADDR_W-1:0]                req_addr,
    input  logic [N_REQ*DATA_W-1:0]                req_wdata,
    output logic [N_REQ-1:0]                       req_ready,
    output logic [N_REQ-1:0]                       rsp_valid,
    output logic [N_REQ*DATA_W-1:0]                rsp_data,
    output logic [(1<<BANK_W)-1:0]                 ram_en,
    output logic [(1<<BANK_W)-1:0]                 ram_we,
    output logic [(1<<BANK_W)*(ADDR_W-BANK_W)-1:0] ram_row,
    output logic [(1<<BANK_W)*DATA_W-1:0]          ram_wdata,
    input  logic [(1<<BANK_W)*DATA_W-1:0]          ram_rdata,
    input  logic                                   stat_clr,
    output logic [15:0]                            conflict_cnt
);
    localparam int N_BANK = 1 << BANK_W;
    localparam int ROW_W  = ADDR_W - BANK_W;
    localparam int REQ_W  = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int DEPTH  = 1 + RAM_LAT;

    logic [REQ_W-1:0]  ptr_q    [N_BANK];
    logic [N_BANK-1:0] bank_gnt;
    logic [REQ_W-1:0]  bank_win [N_BANK];

    logic [DEPTH-1:0]  tag_v    [N_BANK];
    logic [REQ_W-1:0]  tag_id   [N_BANK][DEPTH];

    logic [N_REQ-1:0]        rsp_v_nxt;
    logic [N_REQ*DATA_W-1:0] rsp_d_nxt;

    // Scan from each bank's pointer; grants are suppressed while reset is held.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path infers a latch.
        req_ready = '0;
        for (int b = 0; b < N_BANK; b++) begin
            logic             found;
            logic [REQ_W-1:0] win;
            int               idx;
            found = 1'b0;
            win   = '0;
            for (int k = 0; k < N_REQ; k++) begin
                idx = (int'(ptr_q[b]) + k) % N_REQ;
                if (!found && rst && req_valid[idx] &&
                    req_addr[idx*ADDR_W +: BANK_W] == BANK_W'(b)) begin
                    found = 1'b1;
                    win   = REQ_W'(idx);
                end
            end
            bank_gnt[b] = found;
            bank_win[b] = win;
            if (found) req_ready[win] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        // NOTE: state is written with non-blocking assignments so every register samples pre-edge values.
        if (!rst) begin
            ram_en    <= '0;
            ram_we    <= '0;
            ram_row   <= '0;
            ram_wdata <= '0;
            for (int b = 0; b < N_BANK; b++) begin
                ptr_q[b] <= '0;
                tag_v[b] <= '0;
                for (int s = 0; s < DEPTH; s++) tag_id[b][s] <= '0;
            end
        end else begin
            ram_en <= bank_gnt;
            for (int b = 0; b < N_BANK; b++) begin
                if (bank_gnt[b]) begin
                    ptr_q[b]  <= (bank_win[b] == REQ_W'(N_REQ-1)) ? '0 : bank_win[b] + 1'b1;
                    ram_we[b] <= req_we[bank_win[b]];
                    ram_row[b*ROW_W +: ROW_W]     <= req_addr[int'(bank_win[b])*ADDR_W + BANK_W +: ROW_W];
                    ram_wdata[b*DATA_W +: DATA_W] <= req_wdata[int'(bank_win[b])*DATA_W +: DATA_W];
                end else begin
                    ram_we[b] <= 1'b0;
                end
                // Tag pipe tracks which requester owns the read data emerging from the bank.
                tag_v[b][0]  <= bank_gnt[b] & ~req_we[bank_win[b]];
                tag_id[b][0] <= bank_win[b];
                for (int s = DEPTH-1; s > 0; s--) begin
                    tag_v[b][s]  <= tag_v[b][s-1];
                    tag_id[b][s] <= tag_id[b][s-1];
                end
            end
        end
    end

    // Fixed latency and single issue per cycle guarantee one return per requester per cycle.
    always_comb begin
        rsp_v_nxt = '0;
        rsp_d_nxt = rsp_data;
        for (int b = 0; b < N_BANK; b++) begin
            if (tag_v[b][DEPTH-1]) begin
                rsp_v_nxt[tag_id[b][DEPTH-1]] = 1'b1;
                rsp_d_nxt[int'(tag_id[b][DEPTH-1])*DATA_W +: DATA_W] = ram_rdata[b*DATA_W +: DATA_W];
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rsp_valid <= '0;
            rsp_data  <= '0;
        end else begin
            rsp_valid <= rsp_v_nxt;
            rsp_data  <= rsp_d_nxt;
        end
    end

`ifdef FEAT_ARB_STATS_EN
    // Counts cycles where at least one requester is stalled; clear wins over increment.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            conflict_cnt <= '0;
        end else if (stat_clr) begin
            conflict_cnt <= '0;
        end else if (|(req_valid & ~req_ready) && conflict_cnt != 16'hFFFF) begin
            conflict_cnt <= conflict_cnt + 16'd1;
        end
    end
`else
    logic unused_stat_clr;
    assign unused_stat_clr = stat_clr;
    assign conflict_cnt    = '0;
`endif

endmodule

// File: tb/tb_feat_bank_arb.sv
// Directed self-checking bench for feat_bank_arb with a behavioural one-cycle-latency bank model.
module tb_feat_bank_arb;
    localparam int N_REQ  = 4;
    localparam int ADDR_W = 12;
    localparam int BANK_W = 3;
    localparam int DATA_W = 16;
    localparam int N_BANK = 8;
    localparam int ROW_W  = 9;

    logic                       clk = 1'b0;
    logic                       rst = 1'b0;
    logic [N_REQ-1:0]           req_valid = '0;
    logic [N_REQ-1:0]           req_we = '0;
    logic [N_REQ*ADDR_W-1:0]    req_addr = '0;
    logic [N_REQ*DATA_W-1:0]    req_wdata = '0;
    logic [N_REQ-1:0]           req_ready;
    logic [N_REQ-1:0]           rsp_valid;
    logic [N_REQ*DATA_W-1:0]    rsp_data;
    logic [N_BANK-1:0]          ram_en;
    logic [N_BANK-1:0]          ram_we;
    logic [N_BANK*ROW_W-1:0]    ram_row;
    logic [N_BANK*DATA_W-1:0]   ram_wdata;
    logic [N_BANK*DATA_W-1:0]   ram_rdata;
    logic                       stat_clr = 1'b0;
    logic [15:0]                conflict_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    feat_bank_arb dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
        .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_data(rsp_data),
        .ram_en(ram_en), .ram_we(ram_we), .ram_row(ram_row), .ram_wdata(ram_wdata),
        .ram_rdata(ram_rdata), .stat_clr(stat_clr), .conflict_cnt(conflict_cnt)
    );

    // Unwritten locations read back 16'h0800 | bank<<12 | row.
    logic [DATA_W-1:0] mem     [N_BANK][1<<ROW_W];
    logic              wr_flag [N_BANK][1<<ROW_W];

    always @(posedge clk) begin
        for (int b = 0; b < N_BANK; b++) begin
            if (ram_en[b]) begin
                if (ram_we[b]) begin
                    mem[b][ram_row[b*ROW_W +: ROW_W]]     <= ram_wdata[b*DATA_W +: DATA_W];
                    wr_flag[b][ram_row[b*ROW_W +: ROW_W]] <= 1'b1;
                end else if (wr_flag[b][ram_row[b*ROW_W +: ROW_W]] === 1'b1) begin
                    ram_rdata[b*DATA_W +: DATA_W] <= mem[b][ram_row[b*ROW_W +: ROW_W]];
                end else begin
                    ram_rdata[b*DATA_W +: DATA_W] <= 16'h0800 | 16'(b << 12) | 16'(ram_row[b*ROW_W +: ROW_W]);
                end
            end
        end
    end

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int r, input logic we, input logic [ADDR_W-1:0] addr,
                           input logic [DATA_W-1:0] wd);
        req_valid[r]                 = 1'b1;
        req_we[r]                    = we;
        req_addr[r*ADDR_W +: ADDR_W] = addr;
        req_wdata[r*DATA_W +: DATA_W] = wd;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        // Reset held with random inputs: every output must stay 0.
        for (int i = 0; i < 3; i++) begin
            req_valid = 4'($urandom);
            req_we    = 4'($urandom);
            req_addr  = {16'($urandom), $urandom};
            req_wdata = {$urandom, $urandom};
            stat_clr  = 1'($urandom);
            #7;
            check("rst_ready", 128'(req_ready), 128'h0);
            check("rst_rsp_valid", 128'(rsp_valid), 128'h0);
            check("rst_rsp_data", 128'(rsp_data), 128'h0);
            check("rst_ram_en", 128'(ram_en), 128'h0);
            check("rst_ram_we", 128'(ram_we), 128'h0);
            check("rst_ram_row", 128'(ram_row), 128'h0);
            check("rst_ram_wdata", 128'(ram_wdata), 128'h0);
            check("rst_conflict", 128'(conflict_cnt), 128'h0);
        end
        req_valid = '0;
        req_we    = '0;
        stat_clr  = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        tick();

        // First contention on bank 0 after reset goes to req0.
        set_req(0, 1'b0, 12'h008, 16'h0);
        set_req(2, 1'b0, 12'h010, 16'h0);
        #1;
        check("t1_ready", 128'(req_ready), 128'h1);
        tick();
        req_valid = '0;
        #1;
        check("t1_ram_en", 128'(ram_en), 128'h01);
        check("t1_ram_we", 128'(ram_we), 128'h00);
        check("t1_ram_row0", 128'(ram_row[0 +: ROW_W]), 128'h1);
        tick();
        check("t1_rsp_early", 128'(rsp_valid), 128'h0);
        tick();
        check("t1_rsp_valid", 128'(rsp_valid), 128'h1);
        check("t1_rsp_data0", 128'(rsp_data[0 +: DATA_W]), 128'h0801);

        // Four requesters on four distinct banks, all granted together.
        tick();
        for (int r = 0; r < 4; r++) set_req(r, 1'b0, 12'(r), 16'h0);
        #1;
        check("t2_ready", 128'(req_ready), 128'hF);
        tick();
        req_valid = '0;
        #1;
        check("t2_ram_en", 128'(ram_en), 128'h0F);
        tick();
        tick();
        check("t2_rsp_valid", 128'(rsp_valid), 128'hF);
        check("t2_rsp_data", 128'(rsp_data), 128'h3800_2800_1800_0800);

        // Everyone hammers bank 5: grants rotate 0,1,2,3,0.
        tick();
        set_req(0, 1'b0, 12'h005, 16'h0);
        set_req(1, 1'b0, 12'h00D, 16'h0);
        set_req(2, 1'b0, 12'h015, 16'h0);
        set_req(3, 1'b0, 12'h01D, 16'h0);
        for (int k = 0; k < 8; k++) begin
            if (k == 5) req_valid = '0;
            #1;
            check($sformatf("t3_ready_%0d", k), 128'(req_ready),
                  (k < 5) ? 128'(1 << (k % 4)) : 128'h0);
            check($sformatf("t3_ram_en_%0d", k), 128'(ram_en),
                  (k >= 1 && k <= 5) ? 128'h20 : 128'h0);
            if (k >= 1 && k <= 4)
                check($sformatf("t3_ram_row5_%0d", k), 128'(ram_row[5*ROW_W +: ROW_W]), 128'(k - 1));
            check($sformatf("t3_rsp_valid_%0d", k), 128'(rsp_valid),
                  (k >= 3) ? 128'(1 << ((k - 3) % 4)) : 128'h0);
            if (k >= 3)
                check($sformatf("t3_rsp_data_%0d", k), 128'(rsp_data[((k - 3) % 4)*DATA_W +: DATA_W]),
                      128'(16'h5800 + 16'((k - 3) % 4)));
`ifndef FEAT_ARB_STATS_EN
            if (k == 2) check("t3_conflict_off", 128'(conflict_cnt), 128'h0);
`endif
            tick();
        end

        // Write then read of the same address returns the new data; writes give no response.
        set_req(2, 1'b1, 12'h01A, 16'hABCD);
        #1;
        check("t4_ready_wr", 128'(req_ready), 128'h4);
        tick();
        req_valid = '0;
        set_req(0, 1'b0, 12'h01A, 16'h0);
        #1;
        check("t4_ram_en_wr", 128'(ram_en), 128'h04);
        check("t4_ram_we", 128'(ram_we), 128'h04);
        check("t4_ram_row2", 128'(ram_row[2*ROW_W +: ROW_W]), 128'h3);
        check("t4_ram_wdata2", 128'(ram_wdata[2*DATA_W +: DATA_W]), 128'hABCD);
        check("t4_ready_rd", 128'(req_ready), 128'h1);
        tick();
        req_valid = '0;
        #1;
        check("t4_ram_en_rd", 128'(ram_en), 128'h04);
        check("t4_ram_we_rd", 128'(ram_we), 128'h00);
        check("t4_no_wr_rsp", 128'(rsp_valid), 128'h0);
        tick();
        check("t4_no_rsp_yet", 128'(rsp_valid), 128'h0);
        tick();
        check("t4_rsp_valid", 128'(rsp_valid), 128'h1);
        check("t4_rsp_data0", 128'(rsp_data[0 +: DATA_W]), 128'hABCD);

        // Reset mid-flight drops both outstanding reads.
        tick();
        set_req(1, 1'b0, 12'h007, 16'h0);
        set_req(3, 1'b0, 12'h00E, 16'h0);
        #1;
        check("t5_ready", 128'(req_ready), 128'hA);
        tick();
        req_valid = '0;
        rst = 1'b0;
        #1;
        check("t5_ram_en_rst", 128'(ram_en), 128'h0);
        tick();
        rst = 1'b1;
        for (int k = 0; k < 5; k++) begin
            #1;
            check($sformatf("t5_no_rsp_%0d", k), 128'(rsp_valid), 128'h0);
            tick();
        end

        // Pointers were reset: bank 0 favours req0 again over req1.
        set_req(0, 1'b0, 12'h000, 16'h0);
        set_req(1, 1'b0, 12'h008, 16'h0);
        #1;
        check("t5_ptr_reset", 128'(req_ready), 128'h1);
        tick();
        req_valid = '0;
        repeat (4) tick();

`ifdef FEAT_ARB_STATS_EN
        // Three readers on bank 1, each dropping out once served: two stalled cycles.
        stat_clr = 1'b1;
        tick();
        stat_clr = 1'b0;
        #1;
        check("t6_clr_start", 128'(conflict_cnt), 128'h0);
        set_req(0, 1'b0, 12'h001, 16'h0);
        set_req(1, 1'b0, 12'h009, 16'h0);
        set_req(2, 1'b0, 12'h011, 16'h0);
        #1;
        check("t6_ready0", 128'(req_ready), 128'h1);
        tick();
        req_valid[0] = 1'b0;
        #1;
        check("t6_cnt1", 128'(conflict_cnt), 128'h1);
        check("t6_ready1", 128'(req_ready), 128'h2);
        tick();
        req_valid[1] = 1'b0;
        #1;
        check("t6_cnt2", 128'(conflict_cnt), 128'h2);
        check("t6_ready2", 128'(req_ready), 128'h4);
        tick();
        req_valid = '0;
        #1;
        check("t6_cnt_hold", 128'(conflict_cnt), 128'h2);
        // Clear during a conflicting cycle must still load 0.
        set_req(0, 1'b0, 12'h001, 16'h0);
        set_req(1, 1'b0, 12'h009, 16'h0);
        stat_clr = 1'b1;
        tick();
        stat_clr = 1'b0;
        req_valid = '0;
        #1;
        check("t6_clr_prio", 128'(conflict_cnt), 128'h0);
`else
        // Without the statistics option the counter stays at 0 under conflicts.
        set_req(0, 1'b0, 12'h001, 16'h0);
        set_req(1, 1'b0, 12'h009, 16'h0);
        #1;
        check("t6_ready_off", 128'(req_ready), 128'h1);
        tick();
        req_valid = '0;
        #1;
        check("t6_cnt_off", 128'(conflict_cnt), 128'h0);
`endif
        repeat (4) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
